// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between two mux-fed sources, the arbiter and its downstream consumer.
// ARB_LOCK_EN adds per-source last flags for packet lock.
interface mux_sel_arbiter_if #(parameter int WIDTH = 8);
  logic             in0_valid;
  logic             in0_ready;
  logic             in1_valid;
  logic             in1_ready;
  logic             select;
  logic [WIDTH-1:0] mux_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
`ifdef ARB_LOCK_EN
  logic             in0_last;
  logic             in1_last;
`endif

  modport slave (
`ifdef ARB_LOCK_EN
    input  in0_last, in1_last,
`endif
    input  in0_valid, in1_valid, mux_out, out_ready,
    output in0_ready, in1_ready, select, out_valid, out_data, out_src
  );

  modport master (
`ifdef ARB_LOCK_EN
    output in0_last, in1_last,
`endif
    output in0_valid, in1_valid, mux_out, out_ready,
    input  in0_ready, in1_ready, select, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin front end for a 2:1 mux: drives select, captures mux_out into a registered
// valid/ready stage. Define ARB_LOCK_EN to hold the grant for multi-beat packets.
module mux_sel_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mux_sel_arbiter_if.slave    bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_prio;
  logic             w_space;
  logic             w_req;
  logic             w_grant;
  logic             w_load;
`ifdef ARB_LOCK_EN
  logic             r_lock;
  logic             r_lock_id;
  logic             w_last;
`endif

  assign w_space = !r_out_valid || bus.out_ready;

  always_comb begin
    w_grant = r_prio;
    w_req   = bus.in0_valid || bus.in1_valid;
    if (bus.in0_valid && !bus.in1_valid)
      w_grant = 1'b0;
    else if (bus.in1_valid && !bus.in0_valid)
      w_grant = 1'b1;
`ifdef ARB_LOCK_EN
    // Mid-packet: only the owning source may advance, even if it is idle.
    if (r_lock) begin
      w_grant = r_lock_id;
      w_req   = r_lock_id ? bus.in1_valid : bus.in0_valid;
    end
`endif
  end

  assign w_load        = w_space && w_req;
  assign bus.select    = w_grant;
  assign bus.in0_ready = w_load && !w_grant;
  assign bus.in1_ready = w_load &&  w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
`ifdef ARB_LOCK_EN
  assign w_last = w_grant ? bus.in1_last : bus.in0_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_prio      <= 1'b0;
`ifdef ARB_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_id   <= 1'b0;
`endif
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.mux_out;
      r_out_src   <= w_grant;
`ifdef ARB_LOCK_EN
      if (w_last) begin
        r_prio <= ~w_grant;
        r_lock <= 1'b0;
      end else begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
`else
      r_prio      <= ~w_grant;
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a behavioural 2:1 mux in front of it.
module tb_mux_sel_arbiter;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  int               n_chk;
  int               n_fail;

  mux_sel_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

  mux_sel_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  assign bus_if.mux_out = bus_if.select ? d1 : d0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic ordy);
    bus_if.in0_valid = v0;
    bus_if.in1_valid = v1;
    bus_if.out_ready = ordy;
  endtask

  logic [7:0] seq_data [4];
  logic       seq_src  [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    d0     = 8'h00;
    d1     = 8'h00;
    drive(1'b0, 1'b0, 1'b0);
`ifdef ARB_LOCK_EN
    bus_if.in0_last = 1'b1;
    bus_if.in1_last = 1'b1;
`endif
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_data",  32'(bus_if.out_data),  32'h00);
    chk("rst_src",   32'(bus_if.out_src),   32'd0);

    // Single source
    d0 = 8'hAA;
    drive(1'b1, 1'b0, 1'b1);
    #1;
    chk("single_rdy0", 32'(bus_if.in0_ready), 32'd1);
    chk("single_rdy1", 32'(bus_if.in1_ready), 32'd0);
    chk("single_sel",  32'(bus_if.select),    32'd0);
    step();
    chk("single_valid", 32'(bus_if.out_valid), 32'd1);
    chk("single_data",  32'(bus_if.out_data),  32'hAA);
    chk("single_src",   32'(bus_if.out_src),   32'd0);

    // Idle drain: prio now points at in1
    drive(1'b0, 1'b0, 1'b1);
    #1;
    chk("idle_sel",  32'(bus_if.select),    32'd1);
    chk("idle_rdy0", 32'(bus_if.in0_ready), 32'd0);
    step();
    chk("idle_valid", 32'(bus_if.out_valid), 32'd0);
    chk("idle_hold",  32'(bus_if.out_data),  32'hAA);

    // Alternation from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    d0 = 8'hAA;
    d1 = 8'hCC;
    seq_data = '{8'hAA, 8'hCC, 8'hAA, 8'hCC};
    seq_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_sel%0d", i), 32'(bus_if.select), 32'(seq_src[i]));
      step();
      chk($sformatf("alt_data%0d", i), 32'(bus_if.out_data), 32'(seq_data[i]));
      chk($sformatf("alt_src%0d", i),  32'(bus_if.out_src),  32'(seq_src[i]));
    end

    // Backpressure: load 0xF0 then stall
    d0 = 8'hF0;
    d1 = 8'h0F;
    step();
    chk("bp_load", 32'(bus_if.out_data), 32'hF0);
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy0_%0d", i), 32'(bus_if.in0_ready), 32'd0);
      chk($sformatf("bp_rdy1_%0d", i), 32'(bus_if.in1_ready), 32'd0);
      chk($sformatf("bp_sel_%0d", i),  32'(bus_if.select),    32'd1);
      step();
      chk($sformatf("bp_data_%0d", i),  32'(bus_if.out_data),  32'hF0);
      chk($sformatf("bp_valid_%0d", i), 32'(bus_if.out_valid), 32'd1);
    end
    bus_if.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy1", 32'(bus_if.in1_ready), 32'd1);
    step();
    chk("bp_rel_data",  32'(bus_if.out_data),  32'h0F);
    chk("bp_rel_src",   32'(bus_if.out_src),   32'd1);
    chk("bp_rel_valid", 32'(bus_if.out_valid), 32'd1);

    // Reset with a word in flight
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus_if.out_data),  32'h00);
    rst = 1'b0;
    #1;
    chk("mid_rst_sel",  32'(bus_if.select),    32'd0);
    chk("mid_rst_rdy0", 32'(bus_if.in0_ready), 32'd1);
    step();
    chk("mid_rst_data2", 32'(bus_if.out_data), 32'hF0);
    chk("mid_rst_src",   32'(bus_if.out_src),  32'd0);

`ifdef ARB_LOCK_EN
    // Three-beat packet from in0 locks out in1
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      d0 = 8'(8'h11 * (i + 1));
      bus_if.in0_last = (i == 2);
      #1;
      chk($sformatf("lock_rdy1_%0d", i), 32'(bus_if.in1_ready), 32'd0);
      chk($sformatf("lock_rdy0_%0d", i), 32'(bus_if.in0_ready), 32'd1);
      step();
      chk($sformatf("lock_data_%0d", i), 32'(bus_if.out_data), 32'(8'h11 * (i + 1)));
    end
    #1;
    chk("lock_after_rdy1", 32'(bus_if.in1_ready), 32'd1);
    chk("lock_after_sel",  32'(bus_if.select),    32'd1);
    step();
    chk("lock_after_src", 32'(bus_if.out_src), 32'd1);
`endif

    drive(1'b0, 1'b0, 1'b1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
